// File: rtl/fccc_apb_cfg_master_if.sv
// CCC dynamic-configuration APB port plus the PLL reset/lock handshake.
// The master modport is the initiator side; the slave modport is the CCC/PLL side.
interface fccc_apb_cfg_master_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              BUSY;
    logic              PLL_ARST_N;
    logic              LOCK;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PLL_ARST_N,
        input  PRDATA, BUSY, LOCK
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PLL_ARST_N,
        output PRDATA, BUSY, LOCK
    );
endinterface

// File: rtl/fccc_apb_cfg_master.sv
// APB initiator for the FCCC dynamic-configuration port with PLL reset/lock commit.
// Optional write readback-verify is enabled by defining FCCC_CFG_READBACK_EN.
//
// state       | meaning
// IDLE        | cmd_ready high, waiting for a command
// SETUP       | APB setup phase (PSEL=1, PENABLE=0)
// ACCESS      | APB access phase, extended while BUSY, bounded by TIMEOUT
// RB_SETUP    | readback setup phase of the just-written address (macro only)
// RB_ACCESS   | readback access phase, data compared to wdata (macro only)
// PLL_RST     | PLL_ARST_N held low for RST_CYCLES
// LOCK_WAIT   | waiting for synchronized LOCK, bounded by TIMEOUT
// RESP        | one-cycle rsp_valid
module fccc_apb_cfg_master #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int RST_CYCLES = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic                  PCLK,
    input  logic                  PRESET_N,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  cfg_locked,
    fccc_apb_cfg_master_if.master ccc
);
    localparam logic [1:0]  OP_WR    = 2'b00;
    localparam logic [1:0]  OP_RD    = 2'b01;
    localparam logic [1:0]  OP_COMMIT = 2'b10;
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
`ifdef FCCC_CFG_READBACK_EN
        S_RB_SETUP,
        S_RB_ACCESS,
`endif
        S_PLL_RST,
        S_LOCK_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    logic              r_is_wr;
    logic [15:0]       r_cnt;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_arst_n;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_sync1;
    logic              r_sync2;
`ifdef FCCC_CFG_READBACK_EN
    logic [DATA_W-1:0] r_wdata;
`endif

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ccc.LOCK;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            r_state     <= S_IDLE;
            r_is_wr     <= 1'b0;
            r_cnt       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_arst_n    <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef FCCC_CFG_READBACK_EN
            r_wdata     <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_cnt       <= '0;
                        r_is_wr     <= (cmd_op == OP_WR);
`ifdef FCCC_CFG_READBACK_EN
                        r_wdata     <= cmd_wdata;
`endif
                        if (cmd_op == OP_WR || cmd_op == OP_RD) begin
                            r_state  <= S_SETUP;
                            r_psel   <= 1'b1;
                            r_pwrite <= (cmd_op == OP_WR);
                            r_paddr  <= cmd_addr;
                            r_pwdata <= (cmd_op == OP_WR) ? cmd_wdata : '0;
                        end else if (cmd_op == OP_COMMIT) begin
                            r_state  <= S_PLL_RST;
                            r_arst_n <= 1'b0;
                        end else begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (!ccc.BUSY) begin
`ifdef FCCC_CFG_READBACK_EN
                        if (r_is_wr) begin
                            // Re-address the same register as a read for verification.
                            r_state   <= S_RB_SETUP;
                            r_penable <= 1'b0;
                            r_pwrite  <= 1'b0;
                            r_pwdata  <= '0;
                            r_cnt     <= '0;
                        end else begin
`endif
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= r_is_wr ? '0 : ccc.PRDATA;
                            r_psel      <= 1'b0;
                            r_penable   <= 1'b0;
                            r_pwrite    <= 1'b0;
                            r_paddr     <= '0;
                            r_pwdata    <= '0;
`ifdef FCCC_CFG_READBACK_EN
                        end
`endif
                    end else if (r_cnt == TO_LAST) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_pwrite    <= 1'b0;
                        r_paddr     <= '0;
                        r_pwdata    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
`ifdef FCCC_CFG_READBACK_EN
                S_RB_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_RB_ACCESS;
                end
                S_RB_ACCESS: begin
                    if (!ccc.BUSY || r_cnt == TO_LAST) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ccc.BUSY || (ccc.PRDATA != r_wdata);
                        r_rsp_rdata <= ccc.BUSY ? '0 : ccc.PRDATA;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_paddr     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
`endif
                S_PLL_RST: begin
                    if (r_cnt == RST_LAST) begin
                        r_state  <= S_LOCK_WAIT;
                        r_arst_n <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_LOCK_WAIT: begin
                    if (r_sync2 || r_cnt == TO_LAST) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= !r_sync2;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready      = r_cmd_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_err        = r_rsp_err;
    assign rsp_rdata      = r_rsp_rdata;
    assign cfg_locked     = r_sync2 && (r_state != S_PLL_RST) && (r_state != S_LOCK_WAIT);
    assign ccc.PSEL       = r_psel;
    assign ccc.PENABLE    = r_penable;
    assign ccc.PWRITE     = r_pwrite;
    assign ccc.PADDR      = r_paddr;
    assign ccc.PWDATA     = r_pwdata;
    assign ccc.PLL_ARST_N = r_arst_n;
endmodule

// File: tb/tb_fccc_apb_cfg_master.sv
// Directed bench for fccc_apb_cfg_master: expected responses are queued at issue
// time and compared, including the response cycle, when rsp_valid appears.
module tb_fccc_apb_cfg_master;
    localparam int TO = 100;
    localparam int RC = 16;

    typedef struct {
        int         cyc;
        logic [7:0] rd;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [5:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       cfg_locked;

    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t mon_e;

    fccc_apb_cfg_master_if #(.ADDR_W(6), .DATA_W(8)) ccc_if ();

    fccc_apb_cfg_master #(
        .ADDR_W(6), .DATA_W(8), .RST_CYCLES(RC), .TIMEOUT(TO)
    ) dut (
        .PCLK(clk),
        .PRESET_N(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .cfg_locked(cfg_locked),
        .ccc(ccc_if.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rd));
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            end
        end
    end

    // Returns at the negedge of cycle 1 (the first cycle after acceptance).
    task automatic issue(input logic [1:0] op, input logic [5:0] addr, input logic [7:0] wd,
                         input bit push, input int lat, input logic [7:0] erd, input logic eerr);
        exp_t e;
        @(negedge clk);
        chk("ready_before_accept", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        if (push) begin
            e.cyc = cyc + lat;
            e.rd  = erd;
            e.err = eerr;
            q.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ready_after_accept", 32'(cmd_ready), 32'd0);
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_wait_bound", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_cnt;
        ccc_if.PRDATA = 8'h00;
        ccc_if.BUSY   = 1'b0;
        ccc_if.LOCK   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_psel", 32'(ccc_if.PSEL), 32'd0);
        chk("rst_penable", 32'(ccc_if.PENABLE), 32'd0);
        chk("rst_pwrite", 32'(ccc_if.PWRITE), 32'd0);
        chk("rst_paddr", 32'(ccc_if.PADDR), 32'd0);
        chk("rst_pwdata", 32'(ccc_if.PWDATA), 32'd0);
        chk("rst_arst_n", 32'(ccc_if.PLL_ARST_N), 32'd1);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_err, 1'b0}, 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_locked", 32'(cfg_locked), 32'd0);
        rst_n = 1'b1;

        // Write 0x2A <= 0xC3, no BUSY
        ccc_if.PRDATA = 8'hC3;
`ifdef FCCC_CFG_READBACK_EN
        issue(2'b00, 6'h2A, 8'hC3, 1, 5, 8'hC3, 1'b0);
`else
        issue(2'b00, 6'h2A, 8'hC3, 1, 3, 8'h00, 1'b0);
`endif
        chk("wr_setup_ctl", {29'd0, ccc_if.PSEL, ccc_if.PENABLE, ccc_if.PWRITE}, 32'b101);
        chk("wr_setup_addr", 32'(ccc_if.PADDR), 32'h2A);
        chk("wr_setup_data", 32'(ccc_if.PWDATA), 32'hC3);
        @(negedge clk);
        chk("wr_access_ctl", {29'd0, ccc_if.PSEL, ccc_if.PENABLE, ccc_if.PWRITE}, 32'b111);
        chk("wr_access_addr", 32'(ccc_if.PADDR), 32'h2A);
        chk("wr_access_data", 32'(ccc_if.PWDATA), 32'hC3);
        @(negedge clk);
`ifdef FCCC_CFG_READBACK_EN
        chk("wr_rb_setup_ctl", {29'd0, ccc_if.PSEL, ccc_if.PENABLE, ccc_if.PWRITE}, 32'b100);
        chk("wr_rb_setup_addr", 32'(ccc_if.PADDR), 32'h2A);
`else
        chk("wr_resp_psel", 32'(ccc_if.PSEL), 32'd0);
        chk("wr_resp_paddr", 32'(ccc_if.PADDR), 32'd0);
`endif
        wait_rsp();

        // Read 0x05 with BUSY high for four ACCESS cycles
        ccc_if.PRDATA = 8'h7E;
        ccc_if.BUSY   = 1'b1;
        issue(2'b01, 6'h05, 8'h00, 1, 7, 8'h7E, 1'b0);
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            if (k == 2) chk("rd_access_ctl", {29'd0, ccc_if.PSEL, ccc_if.PENABLE, ccc_if.PWRITE}, 32'b110);
            if (k == 5) chk("rd_extended", {30'd0, ccc_if.PSEL, ccc_if.PENABLE}, 32'b11);
        end
        ccc_if.BUSY = 1'b0;
        wait_rsp();

        // Illegal op
        issue(2'b11, 6'h11, 8'h22, 1, 1, 8'h00, 1'b1);
        chk("illegal_no_apb", {30'd0, ccc_if.PSEL, ccc_if.PENABLE}, 32'd0);
        wait_rsp();

        // Commit, LOCK rises 10 cycles after PLL_ARST_N release
        low_cnt = 0;
        issue(2'b10, 6'h00, 8'h00, 1, RC + 14, 8'h00, 1'b0);
        for (int k = 1; k <= RC + 13; k++) begin
            if (!ccc_if.PLL_ARST_N) low_cnt++;
            if (k == RC + 11) ccc_if.LOCK = 1'b1;
            if (k == RC + 13) chk("commit_locked_masked", 32'(cfg_locked), 32'd0);
            if (k < RC + 13) @(negedge clk);
        end
        chk("commit_arst_low_cycles", 32'(low_cnt), 32'(RC));
        wait_rsp();
        @(negedge clk);
        chk("commit_locked_after", 32'(cfg_locked), 32'd1);

        // Commit with LOCK never asserting
        ccc_if.LOCK = 1'b0;
        issue(2'b10, 6'h00, 8'h00, 1, RC + 1 + TO, 8'h00, 1'b1);
        wait_rsp();
        @(negedge clk);
        chk("lock_to_locked", 32'(cfg_locked), 32'd0);
        chk("lock_to_ready", 32'(cmd_ready), 32'd1);
        chk("lock_to_arst_n", 32'(ccc_if.PLL_ARST_N), 32'd1);

        // BUSY drops on the last allowed ACCESS cycle: success wins
        ccc_if.PRDATA = 8'h5A;
        ccc_if.BUSY   = 1'b1;
        issue(2'b01, 6'h3F, 8'h00, 1, TO + 2, 8'h5A, 1'b0);
        repeat (TO) @(negedge clk);
        ccc_if.BUSY = 1'b0;
        wait_rsp();

        // BUSY stuck: ACCESS times out after TIMEOUT cycles
        ccc_if.BUSY = 1'b1;
        issue(2'b01, 6'h01, 8'h00, 1, TO + 2, 8'h00, 1'b1);
        wait_rsp();
        chk("busy_to_psel", {30'd0, ccc_if.PSEL, ccc_if.PENABLE}, 32'd0);
        ccc_if.BUSY = 1'b0;

        // Write whose readback returns 0x00
        ccc_if.PRDATA = 8'h00;
`ifdef FCCC_CFG_READBACK_EN
        issue(2'b00, 6'h2A, 8'hC3, 1, 5, 8'h00, 1'b1);
`else
        issue(2'b00, 6'h2A, 8'hC3, 1, 3, 8'h00, 1'b0);
`endif
        wait_rsp();

        // Reset during ACCESS with BUSY high
        ccc_if.BUSY = 1'b1;
        issue(2'b01, 6'h07, 8'h00, 0, 0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        chk("mid_access_ctl", {30'd0, ccc_if.PSEL, ccc_if.PENABLE}, 32'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctl", {30'd0, ccc_if.PSEL, ccc_if.PENABLE}, 32'd0);
        chk("async_rst_paddr", 32'(ccc_if.PADDR), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        ccc_if.BUSY = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Reset during PLL_RST releases PLL_ARST_N immediately
        issue(2'b10, 6'h00, 8'h00, 0, 0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("pll_rst_low", 32'(ccc_if.PLL_ARST_N), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_arst_n", 32'(ccc_if.PLL_ARST_N), 32'd1);
        chk("async_rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst2_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
